// File: rtl/ysyx_22051013_axi_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the AXI bridge.
interface ysyx_22051013_axi_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic            if_re;
    logic [AW-1:0]   if_addr;
    logic [2:0]      if_size;
    logic            if_abort;
    logic [DW-1:0]   if_rdata;
    logic            if_valid;

    logic            mem_re;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [2:0]      mem_size;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic [DW-1:0]   mem_rdata;
    logic            mem_valid;

    logic            axi_re;
    logic            axi_we;
    logic [AW-1:0]   axi_addr;
    logic [2:0]      axi_size;
    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic [DW-1:0]   axi_rdata;
    logic            axi_valid;

    // arbiter side
    modport slave (
        input  if_re, if_addr, if_size, if_abort,
        input  mem_re, mem_we, mem_addr, mem_size, mem_wdata, mem_wstrb,
        input  axi_rdata, axi_valid,
        output if_rdata, if_valid, mem_rdata, mem_valid,
        output axi_re, axi_we, axi_addr, axi_size, axi_wdata, axi_wstrb
    );

    // requester/bridge environment side
    modport master (
        output if_re, if_addr, if_size, if_abort,
        output mem_re, mem_we, mem_addr, mem_size, mem_wdata, mem_wstrb,
        output axi_rdata, axi_valid,
        input  if_rdata, if_valid, mem_rdata, mem_valid,
        input  axi_re, axi_we, axi_addr, axi_size, axi_wdata, axi_wstrb
    );
endinterface

// File: rtl/ysyx_22051013_axi_arbiter.sv
// Shares one AXI bridge port between fetch and data: data has priority,
// fetch is forced through after STARVE_MAX consecutive data grants.
//
//   state | meaning
//   IDLE  | sample requests, pick winner, latch command
//   BUSY  | command held on bridge until axi_valid
//   RESP  | one-cycle valid pulse to the winner (suppressed for dropped fetch)
module ysyx_22051013_axi_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 4
) (
    input logic                       clk,
    input logic                       rst,
    ysyx_22051013_axi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t          state_q, state_d;
    logic            grant_mem_q;
    logic            op_we_q;
    logic            drop_q;
    logic [3:0]      starve_q;
    logic [AW-1:0]   addr_q;
    logic [2:0]      size_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;
    logic [DW-1:0]   rdata_q;
    logic            win_if, win_mem;
    logic            if_fire, mem_fire;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        win_if  = 1'b0;
        win_mem = 1'b0;
        case (state_q)
            IDLE: begin
                if (starve_q == STARVE_LIM && bus.if_re) win_if = 1'b1;
                else if (bus.mem_we || bus.mem_re)       win_mem = 1'b1;
                else if (bus.if_re)                      win_if = 1'b1;
                if (win_if || win_mem) state_d = BUSY;
            end
            BUSY:    if (bus.axi_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_mem_q <= 1'b0;
            op_we_q     <= 1'b0;
            drop_q      <= 1'b0;
            starve_q    <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_if) begin
                        grant_mem_q <= 1'b0;
                        op_we_q     <= 1'b0;
                        addr_q      <= bus.if_addr;
                        size_q      <= bus.if_size;
                        wdata_q     <= '0;
                        wstrb_q     <= '0;
                        drop_q      <= bus.if_abort;
                    end else if (win_mem) begin
                        // a simultaneous read stays pending behind the write
                        grant_mem_q <= 1'b1;
                        op_we_q     <= bus.mem_we;
                        addr_q      <= bus.mem_addr;
                        size_q      <= bus.mem_size;
                        wdata_q     <= bus.mem_wdata;
                        wstrb_q     <= bus.mem_wstrb;
                        drop_q      <= 1'b0;
                    end
                    if (win_if || !bus.if_re)
                        starve_q <= '0;
                    else if (win_mem && starve_q != 4'hF)
                        starve_q <= starve_q + 4'd1;
                end
                BUSY: begin
                    if (!grant_mem_q && bus.if_abort) drop_q <= 1'b1;
                    if (bus.axi_valid) rdata_q <= bus.axi_rdata;
                end
                RESP:    drop_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        if_fire       = (state_q == RESP) && !grant_mem_q && !drop_q;
        mem_fire      = (state_q == RESP) && grant_mem_q;
        bus.axi_re    = (state_q == BUSY) && !op_we_q;
        bus.axi_we    = (state_q == BUSY) && op_we_q;
        bus.axi_addr  = addr_q;
        bus.axi_size  = size_q;
        bus.axi_wdata = wdata_q;
        bus.axi_wstrb = wstrb_q;
        bus.if_valid  = if_fire;
        bus.if_rdata  = if_fire ? rdata_q : '0;
        bus.mem_valid = mem_fire;
        bus.mem_rdata = mem_fire ? rdata_q : '0;
    end
endmodule

// File: tb/tb_ysyx_22051013_axi_arbiter.sv
// Self-checking bench: transaction-level arbitration model plus a bridge model
// with random latency, checked cycle by cycle against the arbiter.
module tb_ysyx_22051013_axi_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SM = 4;

    typedef struct {
        bit          is_if;
        bit          we;
        bit          re;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          lat;
        logic [63:0] rdata;
        int          abort;   // 0 none, 1 in granting IDLE, 2 in BUSY
    } txn_t;

    logic clk = 1'b0;
    logic rst;

    ysyx_22051013_axi_arbiter_if #(.AW(AW), .DW(DW)) bus();
    ysyx_22051013_axi_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    txn_t if_q[$];
    txn_t mem_q[$];
    txn_t exp_g[$];
    txn_t cur;
    int   gi = 0, ng = 0, bphase = 0, cnt = 0, resp_due = -1, exp_start = -5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic txn_t mk_if(logic [63:0] a, logic [2:0] sz, int lat, logic [63:0] rd, int ab);
        txn_t t;
        t.is_if = 1'b1; t.we = 1'b0; t.re = 1'b1; t.addr = a; t.size = sz;
        t.wdata = '0; t.wstrb = '0; t.lat = lat; t.rdata = rd; t.abort = ab;
        return t;
    endfunction

    function automatic txn_t mk_mem(bit we, bit re, logic [63:0] a, logic [2:0] sz,
                                    logic [63:0] wd, logic [7:0] ws, int lat, logic [63:0] rd);
        txn_t t;
        t.is_if = 1'b0; t.we = we; t.re = re; t.addr = a; t.size = sz;
        t.wdata = wd; t.wstrb = ws; t.lat = lat; t.rdata = rd; t.abort = 0;
        return t;
    endfunction

    // Expected grant order: both requesters keep requesting while work remains.
    task automatic build_exp();
        txn_t mops[$];
        txn_t t;
        int   ii = 0;
        int   starve = 0;
        bit   ip;
        exp_g.delete();
        foreach (mem_q[k]) begin
            t = mem_q[k];
            if (t.we && t.re) begin
                mops.push_back(t);
                t.we = 1'b0;
                mops.push_back(t);
            end else begin
                if (!t.we) t.we = 1'b0;
                mops.push_back(t);
            end
        end
        while (ii < if_q.size() || mops.size() > 0) begin
            ip = (ii < if_q.size());
            if (ip && starve == SM) begin
                exp_g.push_back(if_q[ii]); ii++; starve = 0;
            end else if (mops.size() > 0) begin
                exp_g.push_back(mops.pop_front());
                starve = ip ? ((starve < 15) ? starve + 1 : 15) : 0;
            end else begin
                exp_g.push_back(if_q[ii]); ii++; starve = 0;
            end
        end
        gi = 0;
        ng = exp_g.size();
    endtask

    task automatic drive();
        if (if_q.size() > 0) begin
            bus.if_re = 1'b1; bus.if_addr = if_q[0].addr; bus.if_size = if_q[0].size;
        end else begin
            bus.if_re = 1'b0; bus.if_addr = r64(); bus.if_size = 3'($urandom);
        end
        if (mem_q.size() > 0) begin
            bus.mem_we = mem_q[0].we; bus.mem_re = mem_q[0].re;
            bus.mem_addr = mem_q[0].addr; bus.mem_size = mem_q[0].size;
            bus.mem_wdata = mem_q[0].wdata; bus.mem_wstrb = mem_q[0].wstrb;
        end else begin
            bus.mem_we = 1'b0; bus.mem_re = 1'b0;
            bus.mem_addr = r64(); bus.mem_size = 3'($urandom);
            bus.mem_wdata = r64(); bus.mem_wstrb = 8'($urandom);
        end
        bus.if_abort = 1'b0;
        if (bphase == 1) begin
            if (cur.is_if) bus.if_abort = (cur.abort == 2 && cnt == 1);
            else           bus.if_abort = 1'($urandom_range(0, 1));
        end else if (cyc == resp_due) begin
            bus.if_abort = 1'($urandom_range(0, 1));
        end else if (gi < ng && cyc == exp_start - 1) begin
            if (exp_g[gi].is_if) bus.if_abort = (exp_g[gi].abort == 1);
            else                 bus.if_abort = 1'($urandom_range(0, 1));
        end
        if (bphase == 1) begin
            bus.axi_valid = (cnt == cur.lat);
            bus.axi_rdata = cur.rdata;
        end else begin
            bus.axi_valid = 1'($urandom_range(0, 1));
            bus.axi_rdata = r64();
        end
    endtask

    task automatic step();
        logic active, exp_ifv, exp_memv;
        @(negedge clk);
        cyc++;
        active = bus.axi_re | bus.axi_we;
        if (bphase == 1 && cnt == cur.lat) begin
            chk("axi_drop", active, 1'b0);
            bphase = 0;
        end else if (bphase == 1) begin
            chk("axi_hold_addr", bus.axi_addr, cur.addr);
            chk("axi_hold_op", {bus.axi_we, bus.axi_re}, {cur.we, !cur.we});
            cnt++;
        end else if (gi < ng && cyc == exp_start) begin
            chk("cmd_start", active, 1'b1);
            if (active) begin
                cur = exp_g[gi];
                gi++;
                chk("cmd_op", {bus.axi_we, bus.axi_re}, {cur.we, !cur.we});
                chk("cmd_addr", bus.axi_addr, cur.addr);
                chk("cmd_size", bus.axi_size, cur.size);
                if (cur.we) begin
                    chk("cmd_wdata", bus.axi_wdata, cur.wdata);
                    chk("cmd_wstrb", bus.axi_wstrb, cur.wstrb);
                end
                bphase = 1;
                cnt = 1;
                resp_due = cyc + cur.lat;
            end
        end else if (active) begin
            chk("cmd_spurious", active, 1'b0);
        end

        exp_ifv  = (cyc == resp_due) && cur.is_if && (cur.abort == 0);
        exp_memv = (cyc == resp_due) && !cur.is_if;
        chk("if_valid", bus.if_valid, exp_ifv);
        chk("mem_valid", bus.mem_valid, exp_memv);
        chk("if_rdata", bus.if_rdata, exp_ifv ? cur.rdata : 64'h0);
        if (!(exp_memv && cur.we))
            chk("mem_rdata", bus.mem_rdata, exp_memv ? cur.rdata : 64'h0);

        if (cyc == resp_due) begin
            if (cur.is_if) begin
                if (if_q.size() > 0) if_q.delete(0);
            end else if (mem_q.size() > 0) begin
                if (mem_q[0].we && mem_q[0].re) mem_q[0].we = 1'b0;
                else mem_q.delete(0);
            end
            exp_start = cyc + 2;
        end
        drive();
    endtask

    task automatic run_scn(input string name);
        int budget = 0;
        build_exp();
        exp_start = cyc + 2;
        while (!(gi == ng && bphase == 0 && cyc > resp_due) && budget < 400) begin
            step();
            budget++;
        end
        chk({name, "_grants"}, 64'(gi), 64'(ng));
        chk({name, "_left"}, 64'(if_q.size() + mem_q.size()), 64'h0);
        repeat (2) step();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_axi_re"}, bus.axi_re, 1'b0);
        chk({name, "_axi_we"}, bus.axi_we, 1'b0);
        chk({name, "_axi_addr"}, bus.axi_addr, 64'h0);
        chk({name, "_axi_size"}, bus.axi_size, 3'h0);
        chk({name, "_axi_wdata"}, bus.axi_wdata, 64'h0);
        chk({name, "_axi_wstrb"}, bus.axi_wstrb, 8'h0);
        chk({name, "_if_valid"}, bus.if_valid, 1'b0);
        chk({name, "_if_rdata"}, bus.if_rdata, 64'h0);
        chk({name, "_mem_valid"}, bus.mem_valid, 1'b0);
        chk({name, "_mem_rdata"}, bus.mem_rdata, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.axi_valid = 1'b0;
        bus.axi_rdata = '0;
        drive();
        repeat (3) begin @(negedge clk); cyc++; end
        chk_all_zero("reset");
        rst = 1'b0;

        // lone fetch with a two-cycle bridge
        if_q.push_back(mk_if(64'h8000_0000, 3'b011, 2, 64'h0000_0013_0000_0093, 0));
        run_scn("lone_fetch");

        // collision: data first, then fetch
        if_q.push_back(mk_if(r64(), 3'b011, $urandom_range(1, 4), r64(), 0));
        mem_q.push_back(mk_mem(1'b0, 1'b1, 64'h8000_1000, 3'b011, r64(), 8'hFF, $urandom_range(1, 4), r64()));
        run_scn("collision");

        // starvation guard
        for (int i = 0; i < 6; i++)
            mem_q.push_back(mk_mem(1'b0, 1'b1, r64(), 3'b011, r64(), 8'hFF, $urandom_range(1, 3), r64()));
        for (int i = 0; i < 2; i++)
            if_q.push_back(mk_if(r64(), 3'b011, $urandom_range(1, 3), r64(), 0));
        run_scn("starve");

        // simultaneous write and read: write first, read after
        mem_q.push_back(mk_mem(1'b1, 1'b1, 64'h8000_3000, 3'b011, 64'hDEAD_BEEF, 8'h0F, 2, r64()));
        run_scn("write_read");

        // aborts: during BUSY, then in the granting IDLE, then a clean fetch
        if_q.push_back(mk_if(64'h8000_4000, 3'b011, 3, r64(), 2));
        if_q.push_back(mk_if(64'h8000_4040, 3'b011, 1, r64(), 1));
        if_q.push_back(mk_if(64'h8000_5000, 3'b010, 2, r64(), 0));
        run_scn("abort");

        // randomized mixes
        for (int s = 0; s < 10; s++) begin
            int nif  = $urandom_range(0, 3);
            int nmem = $urandom_range(0, 5);
            if (nif == 0 && nmem == 0) nmem = 1;
            for (int i = 0; i < nif; i++) begin
                int r = $urandom_range(0, 3);
                if_q.push_back(mk_if(r64(), 3'b011, $urandom_range(1, 4), r64(),
                                     (r < 2) ? 0 : (r == 2 ? 1 : 2)));
            end
            for (int i = 0; i < nmem; i++) begin
                int op = $urandom_range(0, 2);
                mem_q.push_back(mk_mem(op != 0, op != 1, r64(), 3'($urandom), r64(),
                                       8'($urandom), $urandom_range(1, 4), r64()));
            end
            run_scn("random");
        end

        // reset in the middle of a fetch
        if_q.push_back(mk_if(64'h8000_2000, 3'b011, 4, r64(), 0));
        build_exp();
        exp_start = cyc + 2;
        begin
            int b = 0;
            while (!(bphase == 1 && cnt == 2) && b < 20) begin step(); b++; end
        end
        chk("rst_reach_busy", 64'(bphase), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        chk_all_zero("mid_reset");
        if_q.delete();
        mem_q.delete();
        exp_g.delete();
        gi = 0; ng = 0; bphase = 0; resp_due = -1;
        drive();
        repeat (4) step();
        if_q.push_back(mk_if(64'h8000_6000, 3'b011, 2, r64(), 0));
        run_scn("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22051013_axi_arbiter.md
# ysyx_22051013_axi_arbiter

Shares the core's single AXI bridge port between two requesters: the instruction-fetch path (the icache/device-select refill or uncached fetch) and the data path (dcache refill/writeback or uncached load/store). It grants one transaction at a time and holds the granted address, size and write data stable until the bridge completes. It returns the read data to the winner as a one-cycle valid pulse. It sits between the fetch/memory stages and the AXI bridge. Data has priority, with a starvation guard for fetch.

## Interface
- AW, 64, address width
- DW, 64, data width
- STARVE_MAX, 4, consecutive data grants while fetch waits before fetch is forced to win (1..15)

One clock; reset is synchronous and active-high.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- if_re  in  1  fetch read request, held until if_valid
- if_addr  in  AW  fetch address
- if_size  in  3  fetch size (3'b011 cached line beat, 3'b000/3'b010 device)
- if_abort  in  1  fetch squashed (jump/fencei); pending response must be discarded
- if_rdata  out  DW  fetch read data
- if_valid  out  1  one-cycle fetch completion pulse
- mem_re  in  1  data read request, held until mem_valid
- mem_we  in  1  data write request, held until mem_valid
- mem_addr  in  AW  data address
- mem_size  in  3  data size
- mem_wdata  in  DW  write data
- mem_wstrb  in  DW/8  write byte strobes
- mem_rdata  out  DW  data read data
- mem_valid  out  1  one-cycle data completion pulse (reads and writes)
- axi_re  out  1  read command to bridge
- axi_we  out  1  write command to bridge
- axi_addr  out  AW  latched address
- axi_size  out  3  latched size
- axi_wdata  out  DW  latched write data
- axi_wstrb  out  DW/8  latched strobes
- axi_rdata  in  DW  bridge read data
- axi_valid  in  1  bridge completion (read data valid or write response)

## Operation
- States: IDLE, BUSY, RESP. The grant register selects IF or MEM. The drop flag is 1 bit. The starve counter is 4 bits, saturating.
- IDLE: sample requests and pick the winner.
  - Fetch wins if starve == STARVE_MAX and if_re is high.
  - Otherwise data wins if mem_we or mem_re is high.
  - Otherwise fetch wins if if_re is high.
  - With a winner: latch addr, size, wdata, wstrb and the op into command registers, then go to BUSY.
- If mem_we and mem_re are both high, the write is taken; the read stays pending.
- Starve counter:
  - +1 on each data grant while if_re is high.
  - Cleared on a fetch grant or when if_re is low in IDLE.
- BUSY: axi_re or axi_we stays high; axi_addr/size/wdata/wstrb come from the latches. Requester inputs are ignored.
  - On axi_valid: latch axi_rdata, drop axi_re/axi_we, go to RESP.
- RESP: pulse the granted requester's valid for exactly one cycle with the latched rdata, then go to IDLE.
  - Write completions also pulse mem_valid; mem_rdata is don't-care for writes.
- Abort:
  - if_abort high while grant=IF in BUSY, or in the IDLE cycle that grants IF, sets drop.
  - In RESP with drop=1: if_valid stays 0 and drop is cleared.
  - The bus transaction is never cut short.
  - if_abort with grant=MEM or in RESP has no effect.
- Requesters must deassert or renew their request by the cycle after their valid pulse. A request still high in the following IDLE is treated as a new transaction.
- Outputs of the losing requester: valid=0, rdata=0.

## Timing
- Reset:
  - State goes to IDLE; grant, drop and starve go to 0.
  - All outputs go to 0: axi_re, axi_we, axi_addr, axi_size, axi_wdata, axi_wstrb, if_valid, if_rdata, mem_valid, mem_rdata.
  - Reset mid-transaction abandons it silently. The bridge shares rst.
- Request sampled in IDLE at cycle T → axi_re/axi_we high from T+1.
- axi_valid at cycle R → requester valid at R+1. Minimum request-to-valid latency is 3 cycles with a 1-cycle bridge.
- Back-to-back throughput: one transaction per (bridge latency + 2) cycles. The IDLE turnaround cycle is mandatory.
- axi_re/axi_we are registered and never combinationally dependent on requester inputs.
- axi_valid outside BUSY is ignored.

## Test plan
- Lone fetch: if_re=1, if_addr=0x8000_0000, if_size=3'b011; bridge returns 0x0000_0013_0000_0093 after 2 cycles → axi_re high T+1..T+2, if_valid one pulse with that data, mem_valid=0.
- Collision: if_re and mem_re both high in IDLE with mem_addr=0x8000_1000 → data granted first; fetch granted in the next IDLE; exactly one valid pulse each, in that order.
- Starvation: mem_re held continuously with if_re high and STARVE_MAX=4 → 4 data grants, then 1 fetch grant, then data resumes.
- Write+read: mem_we=1, mem_re=1, mem_wstrb=8'h0F, wdata=0xDEAD_BEEF → axi_we with those values; the read issues after the write; two mem_valid pulses.
- Abort: fetch granted, if_abort pulsed during BUSY → the bridge transaction completes, if_valid stays 0, and the next IDLE accepts a new if_addr.
- Reset mid-BUSY: rst asserted for 1 cycle → all outputs 0 the next cycle, state IDLE, no valid pulse emitted; a subsequent fetch works normally.
